// File: rtl/branch_hazard_ctrl_pkg.sv
// branch_hazard_ctrl_pkg
//   Types and helpers for the producer-side branch hazard controller.
//   slot_t       : shadow record of one in-flight instruction {rw, we, ld}
//   REG_ZERO     : architectural $0, which never carries a dependency
//   SLOT_BUBBLE  : empty slot
//   normalize_slot / src_hazard : helpers shared by the slot pipe and the top
package branch_hazard_ctrl_pkg;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [4:0] rw;
    logic       we;
    logic       ld;
  } slot_t;

  localparam slot_t SLOT_BUBBLE = '{rw: REG_ZERO, we: 1'b0, ld: 1'b0};

  // A write to $0 is architecturally a no-op, so it is stored as a plain bubble
  // payload; that keeps RegWrite_MEM / Load_WB from advertising a fake producer.
  function automatic slot_t normalize_slot(input slot_t s);
    slot_t r;
    r = s;
    if (s.rw == REG_ZERO) begin
      r.we = 1'b0;
      r.ld = 1'b0;
    end
    return r;
  endfunction

  // EX results cannot reach ID in time; MEM-stage loads only become
  // forwardable once they reach WB.
  function automatic logic src_hazard(input logic [4:0] src,
                                      input logic [4:0] ex_rw,
                                      input logic       ex_we,
                                      input logic [4:0] mem_rw,
                                      input logic       mem_ld);
    return (src != REG_ZERO) &&
           (((src == ex_rw) && ex_we) || ((src == mem_rw) && mem_ld));
  endfunction

endpackage

// File: rtl/branch_hazard_ctrl_if.sv
// branch_hazard_ctrl_if
//   Bundles the ID-stage request signals and the hazard/forwarding results.
//   master : drives the ID-stage instruction fields and br_taken
//   slave  : the controller; returns stall, flush_ifid, producer info, counters
interface branch_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             id_valid;
  logic             id_is_branch;
  logic             id_is_jr;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic [4:0]       id_rw;
  logic             id_regwrite;
  logic             id_memread;
  logic             br_taken;

  logic             stall;
  logic             flush_ifid;
  logic [4:0]       Rw_MEM;
  logic             RegWrite_MEM;
  logic [4:0]       Rw_WB;
  logic             Load_WB;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] taken_count;

  modport master (
    output id_valid, id_is_branch, id_is_jr, id_rs, id_rt, id_rw,
           id_regwrite, id_memread, br_taken,
    input  stall, flush_ifid, Rw_MEM, RegWrite_MEM, Rw_WB, Load_WB,
           stall_cycles, taken_count
  );

  modport slave (
    input  id_valid, id_is_branch, id_is_jr, id_rs, id_rt, id_rw,
           id_regwrite, id_memread, br_taken,
    output stall, flush_ifid, Rw_MEM, RegWrite_MEM, Rw_WB, Load_WB,
           stall_cycles, taken_count
  );
endinterface

// File: rtl/branch_hazard_ctrl_slot_pipe.sv
// hazard_slot_pipe
//   Three-deep shadow of the EX/MEM/WB destination records.
//   clk, rst_n : clock, async active-low reset
//   advance    : ID instruction moves into EX this edge (else a bubble enters)
//   id_slot    : {rw, we, ld} of the ID instruction
//   ex_*/mem_* : current EX and MEM slot fields
//   wb_rw/wb_ld: current WB slot destination and load flag
module hazard_slot_pipe
  import branch_hazard_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       advance,
  input  slot_t      id_slot,
  output logic [4:0] ex_rw,
  output logic       ex_we,
  output logic [4:0] mem_rw,
  output logic       mem_we,
  output logic       mem_ld,
  output logic [4:0] wb_rw,
  output logic       wb_ld
);

  slot_t ex_q;
  slot_t mem_q;

  // The WB write enable is never consumed downstream, so only rw/ld are kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= SLOT_BUBBLE;
      mem_q <= SLOT_BUBBLE;
      wb_rw <= REG_ZERO;
      wb_ld <= 1'b0;
    end else begin
      wb_rw <= mem_q.rw;
      wb_ld <= mem_q.ld;
      mem_q <= ex_q;
      ex_q  <= advance ? normalize_slot(id_slot) : SLOT_BUBBLE;
    end
  end

  assign ex_rw  = ex_q.rw;
  assign ex_we  = ex_q.we;
  assign mem_rw = mem_q.rw;
  assign mem_we = mem_q.we;
  assign mem_ld = mem_q.ld;

endmodule

// File: rtl/branch_hazard_ctrl.sv
// branch_hazard_ctrl
//   Stalls an ID-stage branch/jr until its sources are forwardable, drives the
//   forwarding unit's producer inputs, flushes IF/ID on a taken branch and
//   counts stall cycles and taken branches.
//   clk, rst_n : clock, async active-low reset
//   bus        : slave side of branch_hazard_ctrl_if (ID request in,
//                stall/flush/producer info/counters out)
module branch_hazard_ctrl
  import branch_hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input logic                 clk,
  input logic                 rst_n,
  branch_hazard_ctrl_if.slave bus
);

  slot_t            id_slot;
  logic [4:0]       ex_rw;
  logic             ex_we;
  logic [4:0]       mem_rw;
  logic             mem_we;
  logic             mem_ld;
  logic [4:0]       wb_rw;
  logic             wb_ld;
  logic             use_rs;
  logic             use_rt;
  logic             rs_haz;
  logic             rt_haz;
  logic             stall_int;
  logic             flush_int;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] taken_cnt;

  assign id_slot = '{rw: bus.id_rw, we: bus.id_regwrite, ld: bus.id_memread};

  hazard_slot_pipe u_slot_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .advance (bus.id_valid & ~stall_int),
    .id_slot (id_slot),
    .ex_rw   (ex_rw),
    .ex_we   (ex_we),
    .mem_rw  (mem_rw),
    .mem_we  (mem_we),
    .mem_ld  (mem_ld),
    .wb_rw   (wb_rw),
    .wb_ld   (wb_ld)
  );

  always_comb begin
    use_rs    = bus.id_valid & (bus.id_is_branch | bus.id_is_jr);
    use_rt    = bus.id_valid & bus.id_is_branch;
    rs_haz    = src_hazard(bus.id_rs, ex_rw, ex_we, mem_rw, mem_ld);
    rt_haz    = src_hazard(bus.id_rt, ex_rw, ex_we, mem_rw, mem_ld);
    stall_int = (use_rs & rs_haz) | (use_rt & rt_haz);
    // Slots are empty under reset so stall is already low; flush is purely
    // input-driven and needs the explicit reset gate.
    flush_int = rst_n & use_rs & bus.br_taken & ~stall_int;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      taken_cnt <= '0;
    end else begin
      if (stall_int) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_int) taken_cnt <= taken_cnt + CNT_W'(1);
    end
  end

  assign bus.stall        = stall_int;
  assign bus.flush_ifid   = flush_int;
  assign bus.Rw_MEM       = mem_rw;
  assign bus.RegWrite_MEM = mem_we;
  assign bus.Rw_WB        = wb_rw;
  assign bus.Load_WB      = wb_ld;
  assign bus.stall_cycles = stall_cnt;
  assign bus.taken_count  = taken_cnt;

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// tb_branch_hazard_ctrl
//   Scoreboard bench: the stimulus process computes the expected outputs from
//   an instruction-history model and queues them; a negedge monitor compares.
module tb_branch_hazard_ctrl;

  localparam int CNT_W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  branch_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

  branch_hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    bit       valid, br, jr, regw, memr, taken;
    bit [4:0] rs, rt, rw;
  } id_t;

  typedef struct {
    bit        stall, flush, we_mem, ld_wb;
    bit [4:0]  rw_mem, rw_wb;
    bit [31:0] sc, tc;
  } exp_t;

  typedef struct {
    bit [4:0] rw;
    bit       we, ld;
  } prod_t;

  exp_t      exp_q[$];
  prod_t     hist[$];   // issued instructions, oldest first: WB, MEM, EX
  bit [31:0] m_sc, m_tc;
  int        vectors = 0;
  int        miscompares = 0;

  function automatic void model_reset();
    prod_t b;
    b = '{rw: 5'd0, we: 1'b0, ld: 1'b0};
    hist.delete();
    for (int k = 0; k < 3; k++) hist.push_back(b);
    m_sc = 0;
    m_tc = 0;
  endfunction

  // Producer d instructions ahead of ID: d=1 blocks on any register write,
  // d=2 only on a load; anything further back is forwarded or already written.
  function automatic bit hazard(input bit [4:0] src);
    prod_t p;
    if (src == 5'd0) return 1'b0;
    for (int d = 1; d <= 2; d++) begin
      p = hist[3-d];
      if (p.rw == src && (d == 1 ? p.we : p.ld)) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic id_t mk(bit v, bit b, bit j, bit [4:0] rs, bit [4:0] rt,
                             bit [4:0] rw, bit rg, bit mr, bit tk);
    id_t i;
    i = '{valid: v, br: b, jr: j, regw: rg, memr: mr, taken: tk,
          rs: rs, rt: rt, rw: rw};
    return i;
  endfunction

  function automatic id_t nop();                  return mk(0,0,0,0,0,0,0,0,0); endfunction
  function automatic id_t alu(bit [4:0] rw);       return mk(1,0,0,0,0,rw,1,0,0); endfunction
  function automatic id_t lw(bit [4:0] rw);        return mk(1,0,0,0,0,rw,1,1,0); endfunction
  function automatic id_t beq(bit [4:0] rs, bit [4:0] rt, bit tk);
    return mk(1,1,0,rs,rt,0,0,0,tk);
  endfunction
  function automatic id_t jr(bit [4:0] rs, bit tk); return mk(1,0,1,rs,0,0,0,0,tk); endfunction

  task automatic apply(input id_t i, input bit rst_lo, output bit st);
    exp_t  e;
    prod_t n;
    bit    fl, ur, ut;
    rst_n            = !rst_lo;
    bus.id_valid     = i.valid;
    bus.id_is_branch = i.br;
    bus.id_is_jr     = i.jr;
    bus.id_rs        = i.rs;
    bus.id_rt        = i.rt;
    bus.id_rw        = i.rw;
    bus.id_regwrite  = i.regw;
    bus.id_memread   = i.memr;
    bus.br_taken     = i.taken;
    if (rst_lo) model_reset();
    ur = i.valid && (i.br || i.jr);
    ut = i.valid && i.br;
    st = !rst_lo && ((ur && hazard(i.rs)) || (ut && hazard(i.rt)));
    fl = !rst_lo && ur && i.taken && !st;
    e.stall  = st;
    e.flush  = fl;
    e.rw_mem = hist[1].rw;
    e.we_mem = hist[1].we;
    e.rw_wb  = hist[0].rw;
    e.ld_wb  = hist[0].ld;
    e.sc     = m_sc;
    e.tc     = m_tc;
    exp_q.push_back(e);
    @(posedge clk);
    if (!rst_lo) begin
      n = '{rw: 5'd0, we: 1'b0, ld: 1'b0};
      if (i.valid && !st && i.rw != 5'd0) n = '{rw: i.rw, we: i.regw, ld: i.memr};
      hist.push_back(n);
      void'(hist.pop_front());
      m_sc = m_sc + 32'(st);
      m_tc = m_tc + 32'(fl);
    end
    #1;
  endtask

  // Holds an instruction in ID until the model says it may proceed.
  task automatic issue(input id_t i);
    bit st;
    int n;
    n = 0;
    do begin
      apply(i, 1'b0, st);
      n++;
    end while (st && n < 4);
    if (st) begin
      miscompares++;
      $display("FAIL issue_timeout: still stalled after %0d cycles, required <= 3", n);
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("stall",        32'(bus.stall),        32'(e.stall));
      chk("flush_ifid",   32'(bus.flush_ifid),   32'(e.flush));
      chk("Rw_MEM",       32'(bus.Rw_MEM),       32'(e.rw_mem));
      chk("RegWrite_MEM", 32'(bus.RegWrite_MEM), 32'(e.we_mem));
      chk("Rw_WB",        32'(bus.Rw_WB),        32'(e.rw_wb));
      chk("Load_WB",      32'(bus.Load_WB),      32'(e.ld_wb));
      chk("stall_cycles", bus.stall_cycles,      e.sc);
      chk("taken_count",  bus.taken_count,       e.tc);
    end
  end

  initial begin
    bit  st;
    id_t r;
    int  w;
    bus.id_valid = 0; bus.id_is_branch = 0; bus.id_is_jr = 0;
    bus.id_rs = 0; bus.id_rt = 0; bus.id_rw = 0;
    bus.id_regwrite = 0; bus.id_memread = 0; bus.br_taken = 0;
    model_reset();
    @(posedge clk);
    #1;
    // reset held with a taken branch present: everything must read zero
    apply(beq(0, 0, 1), 1'b1, st);
    apply(beq(0, 0, 1), 1'b1, st);
    issue(nop());

    // ALU producer immediately ahead: 1 stall
    issue(alu(3));  issue(beq(3, 4, 0));  issue(nop());  issue(nop());
    // load immediately ahead: 2 stalls
    issue(lw(5));   issue(beq(5, 0, 0));  issue(nop());  issue(nop());
    // load two ahead, jr: 1 stall, bubble visible in MEM later
    issue(lw(6));   issue(alu(9));  issue(jr(6, 0));  issue(nop());  issue(nop());
    // write to $0 never hazards; taken branch flushes
    issue(alu(0));  issue(beq(0, 0, 1));  issue(nop());
    // taken held high through a stall: flush only after it clears
    issue(alu(7));  issue(beq(7, 7, 1));  issue(nop());  issue(nop());
    // both sources hit different producers: stall is the max, not the sum
    issue(lw(10));  issue(alu(11));  issue(beq(10, 11, 1));  issue(nop());
    // bal-style branch with a destination enters EX once
    issue(alu(12)); issue(mk(1,1,0,12,0,31,1,0,1)); issue(beq(31, 0, 0)); issue(nop());
    // reset during the second load-use stall cycle; no resumed stall after
    issue(lw(8));
    apply(beq(8, 1, 1), 1'b0, st);
    apply(beq(8, 1, 1), 1'b1, st);
    issue(beq(8, 1, 1));
    issue(nop());

    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        apply(nop(), 1'b1, st);
        continue;
      end
      r = mk($urandom_range(0, 9) != 0, 0, 0,
             5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             5'($urandom_range(0, 7)), 1'($urandom), 1'($urandom), 1'($urandom));
      case ($urandom_range(0, 3))
        0: begin r.br = 1; if ($urandom_range(0, 3) != 0) r.rw = 0; end
        1: begin r.jr = 1; r.rw = 0; end
        default: ;
      endcase
      issue(r);
    end

    w = 0;
    while (exp_q.size() > 0 && w < 10) begin
      @(negedge clk);
      w++;
    end
    #1;
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
